// File: rtl/display_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// display_ctrl_if : core digit stream in, multiplexed 7-segment drive out
// Rev 1.0
// ---------------------------------------------------------------------------
interface display_ctrl_if;
  logic [1:0] status;
  logic [3:0] data;
  logic [3:0] pos;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       commit;

  // master = calculator core / display board side, slave = display_ctrl
  modport master (output status, data, pos, input an, seg, dp, commit);
  modport slave  (input status, data, pos, output an, seg, dp, commit);
endinterface
`default_nettype wire

// File: rtl/display_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// display_ctrl : shadow-buffered 8-digit 7-segment scanner with error override
// Rev 1.0
// ---------------------------------------------------------------------------
module display_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter int NUM_DIGITS  = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  display_ctrl_if.slave  bus
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] c_cnt_max = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] c_blank = 7'h7F;
  localparam logic [6:0] c_dash  = 7'b0111111;
  localparam logic [6:0] c_e     = 7'b0000110;
  localparam logic [6:0] c_r     = 7'b0101111;
  localparam logic [6:0] c_o     = 7'b0100011;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_COMMIT  = 2'd2,
    S_ERROR   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_clear;
  logic            w_wr;
  logic            w_load;

  logic [3:0]      r_shadow [NUM_DIGITS];
  logic [3:0]      r_bank   [NUM_DIGITS];
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_an;
  logic [6:0]      r_seg;
  logic            r_dp;
  logic            r_commit;

  logic            w_print;
  logic            w_err;
  logic            w_pos_ok;
  logic [2:0]      w_wr_idx;
  logic [2:0]      w_msd;
  logic [6:0]      w_seg;
  logic [7:0]      w_an;
  logic            w_dp;

  function automatic logic [6:0] f_bcd7(input logic [3:0] d);
    case (d)
      4'd0:    f_bcd7 = 7'b1000000;
      4'd1:    f_bcd7 = 7'b1111001;
      4'd2:    f_bcd7 = 7'b0100100;
      4'd3:    f_bcd7 = 7'b0110000;
      4'd4:    f_bcd7 = 7'b0011001;
      4'd5:    f_bcd7 = 7'b0010010;
      4'd6:    f_bcd7 = 7'b0000010;
      4'd7:    f_bcd7 = 7'b1111000;
      4'd8:    f_bcd7 = 7'b0000000;
      4'd9:    f_bcd7 = 7'b0010000;
      default: f_bcd7 = c_dash;
    endcase
  endfunction

  assign w_print  = (bus.status == 2'b11);
  assign w_err    = (bus.status == 2'b00);
  assign w_pos_ok = (bus.pos >= 4'd1) && (bus.pos <= 4'd8);
  assign w_wr_idx = 3'(bus.pos - 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Starting a burst (from IDLE or straight out of COMMIT) clears the shadow
  // and still captures the digit presented on that edge, so no slot is lost.
  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    w_wr    = 1'b0;
    w_load  = 1'b0;
    if (w_err) begin
      w_next = S_ERROR;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_print) begin
            w_next  = S_CAPTURE;
            w_clear = 1'b1;
            w_wr    = w_pos_ok;
          end
        end
        S_CAPTURE: begin
          if (w_print) begin
            w_wr = w_pos_ok;
          end else begin
            w_next = S_COMMIT;
            w_load = 1'b1;
          end
        end
        S_COMMIT: begin
          if (w_print) begin
            w_next  = S_CAPTURE;
            w_clear = 1'b1;
            w_wr    = w_pos_ok;
          end else begin
            w_next = S_IDLE;
          end
        end
        S_ERROR: w_next = S_ERROR;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_shadow[i] <= '0;
        r_bank[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_load) begin
          r_bank[i] <= r_shadow[i];
        end
        if (w_wr && (w_wr_idx == 3'(i))) begin
          r_shadow[i] <= bus.data;
        end else if (w_clear) begin
          r_shadow[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (r_cnt == c_cnt_max) begin
      r_cnt <= '0;
      r_idx <= r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Highest nonzero slot; anything above it is blanked, slot 0 always shown.
  always_comb begin
    w_msd = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_bank[i] != 4'd0) begin
        w_msd = 3'(i);
      end
    end
  end

  always_comb begin
    w_seg = c_blank;
    if (r_state == S_ERROR) begin
      case (r_idx)
        3'd3:    w_seg = c_e;
        3'd2:    w_seg = c_r;
        3'd1:    w_seg = c_r;
        3'd0:    w_seg = c_o;
        default: w_seg = c_blank;
      endcase
    end else if (r_idx <= w_msd) begin
      w_seg = f_bcd7(r_bank[r_idx]);
    end
  end

  assign w_an = ~(8'd1 << r_idx);
  assign w_dp = ~((r_idx == 3'd0) && (bus.status == 2'b01));

  // an, seg and dp share one register stage so a slot change never ghosts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an     <= 8'hFF;
      r_seg    <= c_blank;
      r_dp     <= 1'b1;
      r_commit <= 1'b0;
    end else begin
      r_an     <= w_an;
      r_seg    <= w_seg;
      r_dp     <= w_dp;
      r_commit <= w_load;
    end
  end

  assign bus.an     = r_an;
  assign bus.seg    = r_seg;
  assign bus.dp     = r_dp;
  assign bus.commit = r_commit;

endmodule
`default_nettype wire

// File: tb/tb_display_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_display_ctrl : scoreboard bench, directed bursts, error and busy cases
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_display_ctrl;

  localparam int DIV = 4;
  localparam logic [6:0] BL   = 7'h7F;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] D0   = 7'b1000000;
  localparam logic [6:0] D1   = 7'b1111001;
  localparam logic [6:0] D2   = 7'b0100100;
  localparam logic [6:0] D5   = 7'b0010010;
  localparam logic [6:0] D9   = 7'b0010000;
  localparam logic [6:0] SE   = 7'b0000110;
  localparam logic [6:0] SR   = 7'b0101111;
  localparam logic [6:0] SO   = 7'b0100011;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  display_ctrl_if bus ();

  display_ctrl #(
    .REFRESH_DIV (DIV),
    .NUM_DIGITS  (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   commits  = 0;

  logic [7:0] prev_an     = 8'hFF;
  logic       prev_commit = 1'b0;
  int         dwell       = 0;
  bit         chain       = 1'b0;

  // Monitor: each new anode pattern is one presented digit slot.
  always @(negedge clk) begin
    exp_t e;
    if (bus.commit === 1'b1) begin
      commits++;
      checks++;
      if (prev_commit === 1'b1) begin
        failures++;
        $display("FAIL commit_width: commit high on two consecutive cycles");
      end
    end
    prev_commit = bus.commit;
    if (bus.an !== prev_an) begin
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checks++;
        if ({bus.an, bus.seg, bus.dp} !== e) begin
          failures++;
          $display("FAIL slot: got an=%h seg=%b dp=%b, want an=%h seg=%b dp=%b",
                   bus.an, bus.seg, bus.dp, e.an, e.seg, e.dp);
        end
        if (chain) begin
          checks++;
          if (dwell != DIV) begin
            failures++;
            $display("FAIL dwell: an=%h previous slot held %0d clk, want %0d",
                     bus.an, dwell, DIV);
          end
        end
        chain = 1'b1;
      end else begin
        chain = 1'b0;
      end
      dwell   = 1;
      prev_an = bus.an;
    end else begin
      dwell++;
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic drive(input logic [1:0] st, input logic [3:0] p, input logic [3:0] d);
    bus.status = st;
    bus.pos    = p;
    bus.data   = d;
    @(negedge clk);
  endtask

  // segs = {slot7..slot0}; pushes a full scan starting at slot 0 after a 7F->FE wrap.
  task automatic check_frame(input string name, input logic [55:0] segs, input logic dp0);
    exp_t e;
    int   n;
    n = 0;
    while (bus.an === 8'h7F && n < 200) begin @(negedge clk); n++; end
    while (bus.an !== 8'h7F && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout waiting for slot 7, an=%h", name, bus.an);
      return;
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      e.an  = ~(8'd1 << i);
      e.seg = segs[i*7 +: 7];
      e.dp  = (i == 0) ? dp0 : 1'b1;
      sbq.push_back(e);
    end
    n = 0;
    while (sbq.size() > 0 && n < 200) begin @(negedge clk); n++; end
    if (sbq.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout, %0d slots never presented", name, sbq.size());
      sbq.delete();
    end
  endtask

  logic [3:0] burst [8] = '{4'd5, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};

  initial begin
    bus.status = 2'b10;
    bus.pos    = 4'd0;
    bus.data   = 4'd0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_an",     16'(bus.an),     16'h00FF);
    check("reset_seg",    16'(bus.seg),    16'h007F);
    check("reset_dp",     16'(bus.dp),     16'h0001);
    check("reset_commit", 16'(bus.commit), 16'h0000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_an",  16'(bus.an),  16'h00FE);
    check("first_seg", 16'(bus.seg), 16'(D0));
    @(negedge clk);
    check_frame("after_reset", {BL, BL, BL, BL, BL, BL, BL, D0}, 1'b1);

    // Burst "125"
    drive(2'b11, 4'd0, 4'd0);
    for (int p = 1; p <= 8; p++) drive(2'b11, 4'(p), burst[p-1]);
    drive(2'b10, 4'd0, 4'd0);
    repeat (3) @(negedge clk);
    check("commits_burst1", 16'(commits), 16'd1);
    check_frame("show_125", {BL, BL, BL, BL, BL, D1, D2, D5}, 1'b1);

    // Second burst held open: bank must still show "125"
    drive(2'b11, 4'd0, 4'd0);
    for (int p = 1; p <= 8; p++) drive(2'b11, 4'(p), 4'd9);
    drive(2'b11, 4'd0, 4'd0);
    check_frame("mid_burst", {BL, BL, BL, BL, BL, D1, D2, D5}, 1'b1);
    check("commits_mid", 16'(commits), 16'd1);
    drive(2'b10, 4'd0, 4'd0);
    repeat (3) @(negedge clk);
    check("commits_burst2", 16'(commits), 16'd2);
    check_frame("show_9s", {D9, D9, D9, D9, D9, D9, D9, D9}, 1'b1);

    // Error mid-burst, later traffic ignored
    drive(2'b11, 4'd0, 4'd0);
    for (int p = 1; p <= 3; p++) drive(2'b11, 4'(p), 4'd7);
    drive(2'b00, 4'd0, 4'd0);
    drive(2'b10, 4'd0, 4'd0);
    drive(2'b11, 4'd1, 4'd3);
    drive(2'b11, 4'd2, 4'd3);
    drive(2'b10, 4'd0, 4'd0);
    repeat (3) @(negedge clk);
    check("commits_error", 16'(commits), 16'd2);
    check_frame("show_erro", {BL, BL, BL, BL, SE, SR, SR, SO}, 1'b1);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rerst_an", 16'(bus.an), 16'h00FF);
    rst_n = 1'b1;
    check_frame("after_rerst", {BL, BL, BL, BL, BL, BL, BL, D0}, 1'b1);

    // Busy indicator, then out-of-range digit
    bus.status = 2'b01;
    check_frame("busy_dp", {BL, BL, BL, BL, BL, BL, BL, D0}, 1'b0);
    drive(2'b11, 4'd0, 4'd0);
    drive(2'b11, 4'd1, 4'hC);
    drive(2'b01, 4'd0, 4'd0);
    repeat (3) @(negedge clk);
    check("commits_dash", 16'(commits), 16'd3);
    check_frame("show_dash", {BL, BL, BL, BL, BL, BL, BL, DASH}, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
